// File: rtl/sort_unloader.sv
// Streams a captured sorted vector out one element per transfer, ascending or descending,
// with valid/ready handshaking on both sides and zero-bubble back-to-back vector loading.
module sort_unloader #(
  parameter int WIDTH = 32,
  parameter int N     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*WIDTH-1:0]      in_data,
  input  logic                    in_desc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic [$clog2(N)-1:0]    out_idx,
  output logic                    busy
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] mem_q [N];
  logic signed [WIDTH-1:0] mem_d [N];
  logic                    desc_q, desc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    at_end;
  logic                    xfer;
  logic                    load;

  // Final element sits at the far end of the traversal direction.
  assign at_end = (idx_q == (desc_q ? '0 : IDX_MAX));
  assign xfer   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      desc_q  <= 1'b0;
      idx_q   <= '0;
      for (int k = 0; k < N; k++) mem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      idx_q   <= idx_d;
      for (int k = 0; k < N; k++) mem_q[k] <= mem_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = STREAM;
          load    = 1'b1;
        end
      end
      STREAM: begin
        if (xfer && at_end) begin
          if (in_valid) load = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < N; k++) mem_d[k] = mem_q[k];
    desc_d = desc_q;
    idx_d  = idx_q;
    if (load) begin
      for (int k = 0; k < N; k++) mem_d[k] = in_data[k*WIDTH +: WIDTH];
      desc_d = in_desc;
      idx_d  = in_desc ? IDX_MAX : '0;
    end else if (xfer && !at_end) begin
      idx_d = desc_q ? idx_q - IW'(1) : idx_q + IW'(1);
    end
  end

  // in_ready is gated by rst so it reads 0 throughout reset, not just after the first edge.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE:   in_ready = 1'b1;
        STREAM: begin
          out_valid = 1'b1;
          busy      = 1'b1;
          out_last  = at_end;
          in_ready  = out_ready && at_end;
        end
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign out_data = mem_q[idx_q];
  assign out_idx  = idx_q;

endmodule

// File: tb/tb_sort_unloader.sv
// Scoreboard bench for sort_unloader (N=4, WIDTH=8): stimulus queues expected elements,
// a negedge monitor pops and compares each accepted output element.
module tb_sort_unloader;
  localparam int W = 8;
  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_desc = 1'b0;
  logic                out_ready = 1'b1;
  logic [N*W-1:0]      in_data = '0;
  logic                in_ready;
  logic                out_valid;
  logic                out_last;
  logic                busy;
  logic signed [W-1:0] out_data;
  logic [1:0]          out_idx;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  sort_unloader #(.WIDTH(W), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_desc  (in_desc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_idx  (out_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every handshake consumes exactly one expected element.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got data=%0h idx=%0d with nothing expected",
                 out_data, out_idx);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_elem", {21'd0, out_data, out_idx, out_last},
              {21'd0, mon_e.d, mon_e.idx, mon_e.last});
      end
    end
  end

  task automatic push_exp(input logic [31:0] v, input logic desc);
    for (int k = 0; k < N; k++) begin
      exp_t e;
      int   i;
      i      = desc ? (N - 1 - k) : k;
      e.d    = v[i*8 +: 8];
      e.idx  = 2'(i);
      e.last = (k == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [31:0] v, input logic desc);
    bit ok;
    ok       = 1'b0;
    in_data  = v;
    in_desc  = desc;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    push_exp(v, desc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hA5A5_A5A5;
    in_desc  = ~desc;
    check("first_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("drained", exp_q.size(), 32'd0);
    check("busy_low", {31'd0, busy}, 32'd0);
    check("valid_low", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic wait_idx(input logic [1:0] target);
    for (int t = 0; t < 10 && out_idx != target; t++) begin
      @(posedge clk);
      #1;
    end
    check("reach_idx", {30'd0, out_idx}, {30'd0, target});
  endtask

  initial begin
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_idx", {30'd0, out_idx}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);

    // Ascending {-3,1,5,7}
    send(32'h0705_01FD, 1'b0);
    check("busy_high", {31'd0, busy}, 32'd1);
    check("stream_in_ready", {31'd0, in_ready}, 32'd0);
    drain();

    // Descending, same vector
    send(32'h0705_01FD, 1'b1);
    check("desc_first_idx", {30'd0, out_idx}, 32'd3);
    drain();

    // Backpressure on element 5
    send(32'h0705_01FD, 1'b0);
    wait_idx(2'd2);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_data", {24'd0, out_data}, 32'h05);
      check("bp_idx", {30'd0, out_idx}, 32'd2);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();

    // Back-to-back: second vector {0,2,4,6} offered during the last transfer
    send(32'h0705_01FD, 1'b0);
    send(32'h0604_0200, 1'b0);
    check("b2b_first_data", {24'd0, out_data}, 32'd0);
    check("b2b_first_idx", {30'd0, out_idx}, 32'd0);
    drain();

    // Reset mid-stream after two transfers
    send(32'h0705_01FD, 1'b0);
    wait_idx(2'd2);
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_data", {24'd0, out_data}, 32'd0);
    check("mrst_idx", {30'd0, out_idx}, 32'd0);
    check("mrst_last", {31'd0, out_last}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mrst_hold_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rel_ready", {31'd0, in_ready}, 32'd1);
      check("rel_valid", {31'd0, out_valid}, 32'd0);
    end

    // Extremes {-128,-1,0,127}, both directions
    send(32'h7F00_FF80, 1'b0);
    drain();
    send(32'h7F00_FF80, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sort_unloader.md
SORT_UNLOADER -- requirements
Module: sort_unloader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the bit width of one signed element.
REQ-002 SHALL have parameter N, default 8, meaning the elements per vector; N SHALL be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning an asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning a sorted vector is presented on in_data.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block accepts a vector this cycle.
REQ-007 SHALL have port in_data, input, N*WIDTH bits, meaning the sorted vector; element k is in_data[k*WIDTH +: WIDTH], signed.
REQ-008 SHALL have port in_desc, input, 1 bit, meaning readout order: 0 emits element 0 first, 1 emits element N-1 first.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning out_data holds a valid element.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning the downstream consumer accepts the element.
REQ-011 SHALL have port out_data, output, WIDTH bits, signed, meaning the current element.
REQ-012 SHALL have port out_last, output, 1 bit, meaning out_data is the final element of the vector.
REQ-013 SHALL have port out_idx, output, clog2(N) bits, meaning the source element index of out_data.
REQ-014 SHALL have port busy, output, 1 bit, meaning a vector is held and not yet fully emitted.

Function
REQ-015 SHALL implement a two-state FSM with states IDLE and STREAM.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 In IDLE, in_valid=1 SHALL capture in_data and in_desc into internal registers and move the FSM to STREAM on the next edge.
REQ-018 The first element SHALL appear on out_data with out_valid=1 exactly one cycle after acceptance.
REQ-019 The first element SHALL be index 0 if the captured in_desc is 0, and index N-1 if it is 1.
REQ-020 A transfer SHALL occur on every edge where out_valid and out_ready are both 1.
REQ-021 Each transfer SHALL advance the index by +1 when in_desc is 0 and by -1 when in_desc is 1.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-023 out_last SHALL be 1 only for the N-th element, which is index N-1 (ascending) or index 0 (descending).
REQ-024 In STREAM, in_ready SHALL be the combinational AND of out_valid, out_ready and out_last, so back-to-back vectors are accepted with no idle cycle.
REQ-025 A last-element transfer coinciding with in_valid=1 SHALL capture the new vector; its first element SHALL appear on the next cycle, keeping out_valid continuously at 1.
REQ-026 A last-element transfer with in_valid=0 SHALL return the FSM to IDLE, with out_valid=0 on the next cycle.
REQ-027 A change on in_data or in_desc after capture SHALL have no effect on the vector being emitted.
REQ-028 busy SHALL be 1 exactly when the FSM is in STREAM.
REQ-029 Each vector SHALL yield exactly N transfers; no element SHALL be dropped or duplicated.
REQ-030 The index SHALL never wrap past 0 or N-1.
REQ-031 Element values SHALL be passed unmodified; the block SHALL perform no arithmetic on data.

Reset
REQ-032 While rst=0, the FSM SHALL be in IDLE, in_ready=0, out_valid=0, out_data=0, out_last=0, out_idx=0 and busy=0, independent of clk.
REQ-033 Assertion of rst mid-stream SHALL discard the held vector immediately; no further elements SHALL be emitted for it.
REQ-034 After rst returns to 1, in_ready SHALL be 1 from the first clock edge onward.

Verification (N=4, WIDTH=8)
REQ-035 Ascending: accept {-3,1,5,7} (element 0 = -3) with in_desc=0 and out_ready held 1 -> out_data -3,1,5,7 on cycles 1-4, out_idx 0..3, out_last only on 7, busy falls after cycle 4.
REQ-036 Descending: same vector with in_desc=1 -> out_data 7,5,1,-3, out_idx 3..0, out_last on -3.
REQ-037 Backpressure: drop out_ready to 0 for 3 cycles while element 5 is shown -> 5 held stable and out_idx=2 held, then the sequence resumes with no loss or duplicate.
REQ-038 Back-to-back: present a second vector {0,2,4,6} with in_valid=1 during the last transfer of the first -> in_ready=1 on that cycle, out_valid never drops, and 0 follows 7 directly.
REQ-039 Reset mid-stream: drive rst=0 after 2 transfers -> all outputs are 0 asynchronously; after release, in_ready=1 and no residual element appears.
REQ-040 Extremes: accept {-128,-1,0,127} -> output values are bit-exact, confirming signed pass-through.
